// File: rtl/vend_ctrl.sv
// Coffee vending controller: credits 50/100/200-unit coins, strobes a dispense
// once credit reaches PRICE_UNITS, then pays surplus back one 50-unit coin per ack.
module vend_ctrl #(
   parameter int PRICE_UNITS      = 6,
   parameter int MAX_CREDIT_UNITS = 9,
   parameter int CW               = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in50,
   input  logic          in100,
   input  logic          in200,
   input  logic          cancel,
   input  logic          change_ack,
   output logic          give_coffee,
   output logic          change_valid,
   output logic          coin_reject,
   output logic          busy,
   output logic [CW-1:0] credit
);

   typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

   // Widened by one bit so credit+coin can never wrap before the ceiling check.
   localparam logic [CW:0] PRICE_W = (CW+1)'(PRICE_UNITS);
   localparam logic [CW:0] MAX_W   = (CW+1)'(MAX_CREDIT_UNITS);

   state_t        state_q, state_d;
   logic [CW-1:0] credit_q, credit_d;
   logic          reject_q, reject_d;
   logic          give_coffee_q, change_valid_q, busy_q;
   logic [CW:0]   coin_v, sum;
   logic          coin_any, coin_multi;

   always_comb begin
      coin_any   = in50 | in100 | in200;
      coin_multi = (in50 & in100) | (in50 & in200) | (in100 & in200);
      coin_v     = '0;
      if (in50)       coin_v = (CW+1)'(1);
      else if (in100) coin_v = (CW+1)'(2);
      else if (in200) coin_v = (CW+1)'(4);
      sum      = {1'b0, credit_q} + coin_v;
      state_d  = state_q;
      credit_d = credit_q;
      // A coin is always refused when it arrives with another coin, with cancel,
      // or while the machine is vending or paying change.
      reject_d = coin_any & (coin_multi | cancel | (state_q == VEND) | (state_q == CHANGE));
      case (state_q)
         IDLE, COLLECT: begin
            if (cancel) begin
               if (state_q == COLLECT) state_d = CHANGE;
            end else if (coin_any && !coin_multi) begin
               if (sum > MAX_W) begin
                  reject_d = 1'b1;
               end else begin
                  credit_d = sum[CW-1:0];
                  state_d  = (sum >= PRICE_W) ? VEND : COLLECT;
               end
            end
         end
         VEND: begin
            credit_d = credit_q - PRICE_W[CW-1:0];
            state_d  = ({1'b0, credit_q} > PRICE_W) ? CHANGE : IDLE;
         end
         CHANGE: begin
            if (change_ack) begin
               credit_d = credit_q - CW'(1);
               if (credit_q == CW'(1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         credit_q       <= '0;
         reject_q       <= 1'b0;
         give_coffee_q  <= 1'b0;
         change_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         reject_q       <= reject_d;
         give_coffee_q  <= (state_d == VEND);
         change_valid_q <= (state_d == CHANGE);
         busy_q         <= (state_d == VEND) || (state_d == CHANGE);
      end
   end

   assign give_coffee  = give_coffee_q;
   assign change_valid = change_valid_q;
   assign coin_reject  = reject_q;
   assign busy         = busy_q;
   assign credit       = credit_q;

endmodule
